// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encodings and constants for the hazard controller
package hazard_ctrl_pkg;

    typedef enum logic {
        HZ_RUN     = 1'b0,
        HZ_MC_WAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0]  INIT_5   = 5'd0;
    localparam logic [31:0] INIT_32  = 32'd0;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_is_mc;
    logic             exe_is_load;
    logic [4:0]       exe_wr_addr;
    logic             exe_branch_taken;
    logic             mc_done;
    logic             mc_start;
    logic             pc_hold;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_exe_pause;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cnt;

    // Master is the pipeline side; slave is the hazard controller.
    modport master (
        output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_is_mc,
               exe_is_load, exe_wr_addr, exe_branch_taken, mc_done,
        input  mc_start, pc_hold, if_id_hold, if_id_flush, id_exe_pause,
               mc_timeout, stall_cnt
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_is_mc,
               exe_is_load, exe_wr_addr, exe_branch_taken, mc_done,
        output mc_start, pc_hold, if_id_hold, if_id_flush, id_exe_pause,
               mc_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// rtl/hazard_ctrl_load_use_detect.sv - load-use dependency comparator between ID and EXE
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs_addr,
    input  logic [4:0] i_rt_addr,
    input  logic       i_rs_used,
    input  logic       i_rt_used,
    input  logic       i_exe_is_load,
    input  logic [4:0] i_exe_wr_addr,
    output logic       o_lu
);
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_rs_used && (i_rs_addr == i_exe_wr_addr);
    assign w_rt_hit = i_rt_used && (i_rt_addr == i_exe_wr_addr);

    // Register zero is never a real dependency.
    assign o_lu = i_exe_is_load && (i_exe_wr_addr != REG_ZERO) && (w_rs_hit || w_rt_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and mult/div sequencing for the 5-stage pipeline
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz_if
);
    localparam int TO_W = $clog2(MC_TIMEOUT);

    hz_state_t        r_state;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_mc_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_lu;
    logic w_to_hit;
    logic w_start;
    logic w_hold;
    logic w_flush;
    logic w_pause;

    load_use_detect u_lu (
        .i_rs_addr     (hz_if.id_rs_addr),
        .i_rt_addr     (hz_if.id_rt_addr),
        .i_rs_used     (hz_if.id_rs_used),
        .i_rt_used     (hz_if.id_rt_used),
        .i_exe_is_load (hz_if.exe_is_load),
        .i_exe_wr_addr (hz_if.exe_wr_addr),
        .o_lu          (w_lu)
    );

    assign w_to_hit = (r_to_cnt == TO_W'(MC_TIMEOUT - 1)) && !hz_if.mc_done;

    // Mealy decode; everything is gated off while reset is held.
    always_comb begin
        w_start = 1'b0;
        w_hold  = 1'b0;
        w_flush = 1'b0;
        w_pause = 1'b0;
        case (r_state)
            HZ_RUN: begin
                if (hz_if.exe_branch_taken) begin
                    w_flush = 1'b1;
                    w_pause = 1'b1;
                end else if (w_lu) begin
                    w_hold  = 1'b1;
                    w_pause = 1'b1;
                end else if (hz_if.id_is_mc) begin
                    w_start = 1'b1;
                    w_hold  = 1'b1;
                    w_pause = 1'b1;
                end
            end
            HZ_MC_WAIT: begin
                if (!hz_if.mc_done && !w_to_hit) begin
                    w_hold  = 1'b1;
                    w_pause = 1'b1;
                end
            end
            default: ;
        endcase
        if (!rst) begin
            w_start = 1'b0;
            w_hold  = 1'b0;
            w_flush = 1'b0;
            w_pause = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= HZ_RUN;
            r_to_cnt     <= '0;
            r_mc_timeout <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            case (r_state)
                HZ_RUN: begin
                    if (w_start) begin
                        r_state  <= HZ_MC_WAIT;
                        r_to_cnt <= '0;
                    end
                end
                HZ_MC_WAIT: begin
                    if (hz_if.mc_done) begin
                        r_state <= HZ_RUN;
                    end else if (w_to_hit) begin
                        r_state      <= HZ_RUN;
                        r_mc_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_state <= HZ_RUN;
            endcase
            if (w_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign hz_if.mc_start     = w_start;
    assign hz_if.pc_hold      = w_hold;
    assign hz_if.if_id_hold   = w_hold;
    assign hz_if.if_id_flush  = w_flush;
    assign hz_if.id_exe_pause = w_pause;
    assign hz_if.mc_timeout   = r_mc_timeout;
    assign hz_if.stall_cnt    = r_stall_cnt;
endmodule
